poly_sound_generator: RTL and testbench

- Parametrised multi-voice successor to the single-voice SN76477-style generator: NUM_CH independent voices, each with square tone, shared-LFSR noise, mixer mode and attack/sustain/release envelope.
- Voices are summed and driven through a first-order delta-sigma modulator to a 1-bit spkr output feeding the Pmod AMP2.
- Configured at run time through a small register write port, replacing the fixed constant inputs of the previous generation.

---
 rtl/poly_sound_generator.sv | 257 +++++++++++++++++++++++++
 tb/tb_poly_sound_generator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/poly_sound_generator.sv
// Multi-voice square/noise sound generator with ASR envelopes, a summing mixer and a
// first-order delta-sigma 1-bit output. Optional vibrato LFO is enabled by LFO_EN.
module poly_sound_generator #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned FREQ_W   = 12,
  parameter int unsigned PRESCALE = 25,
  parameter int unsigned ENV_DIV  = 256,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_addr,
  input  logic [15:0]       cfg_data,
  input  logic [NUM_CH-1:0] key_on,
  output logic [NUM_CH-1:0] busy,
  output logic              spkr
);

  localparam int unsigned MIX_W  = 4 + ((NUM_CH > 1) ? $clog2(NUM_CH) : 0);
  localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DIV_W  = $clog2(ENV_DIV + 1);
  localparam int unsigned STEP_W = DIV_W + 9;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

  logic [FREQ_W-1:0] tone_period  [NUM_CH];
  logic [FREQ_W-1:0] noise_period [NUM_CH];
  logic [1:0]        mix          [NUM_CH];
  logic [3:0]        sustain      [NUM_CH];
  logic [7:0]        attack_rate  [NUM_CH];
  logic [7:0]        release_rate [NUM_CH];
  logic              unused_cfg;

  assign unused_cfg = ^cfg_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        tone_period[i]  <= '0;
        noise_period[i] <= '0;
        mix[i]          <= '0;
        sustain[i]      <= '0;
        attack_rate[i]  <= '0;
        release_rate[i] <= '0;
      end
    end else if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
      case (cfg_addr)
        2'd0: tone_period[cfg_ch]  <= cfg_data[FREQ_W-1:0];
        2'd1: noise_period[cfg_ch] <= cfg_data[FREQ_W-1:0];
        2'd2: begin
          mix[cfg_ch]     <= cfg_data[9:8];
          sustain[cfg_ch] <= cfg_data[3:0];
        end
        default: begin
          release_rate[cfg_ch] <= cfg_data[15:8];
          attack_rate[cfg_ch]  <= cfg_data[7:0];
        end
      endcase
    end
  end

  logic [PS_W-1:0] pcnt;
  logic            tick;
  logic [15:0]     lfsr;

  assign tick = (pcnt == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
      lfsr <= 16'hACE1;
    end else begin
      pcnt <= tick ? '0 : pcnt + PS_W'(1);
      if (tick) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  logic [FREQ_W-1:0] tone_reload [NUM_CH];

`ifdef LFO_EN
  localparam int unsigned SUM_W = ((FREQ_W > 8) ? FREQ_W : 8) + 1;
  logic [DIV_W-1:0] lfo_div;
  logic [7:0]       lfo;
  logic             lfo_down;
  logic [3:0]       lfo_shift;
  logic [7:0]       lfo_add;

  assign lfo_shift = release_rate[0][7:4];
  assign lfo_add   = (lfo_shift >= 4'd7) ? lfo : (lfo >> (3'd7 - lfo_shift[2:0]));

  // Triangle bounces between 0 and 255 without repeating the end points.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfo_div  <= '0;
      lfo      <= '0;
      lfo_down <= 1'b0;
    end else if (tick) begin
      if (lfo_div == DIV_W'(ENV_DIV - 1)) begin
        lfo_div <= '0;
        if (!lfo_down) begin
          if (lfo == 8'hFF) begin lfo_down <= 1'b1; lfo <= 8'hFE; end
          else lfo <= lfo + 8'd1;
        end else begin
          if (lfo == 8'h00) begin lfo_down <= 1'b0; lfo <= 8'h01; end
          else lfo <= lfo - 8'd1;
        end
      end else begin
        lfo_div <= lfo_div + DIV_W'(1);
      end
    end
  end

  always_comb begin
    logic [SUM_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      s = SUM_W'(tone_period[i]) + SUM_W'(lfo_add);
      tone_reload[i] = (s > SUM_W'({FREQ_W{1'b1}})) ? '1 : s[FREQ_W-1:0];
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) tone_reload[i] = tone_period[i];
  end
`endif

  logic [FREQ_W-1:0] tcnt [NUM_CH];
  logic [FREQ_W-1:0] ncnt [NUM_CH];
  logic [NUM_CH-1:0] sq, nz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        tcnt[i] <= '0;
        ncnt[i] <= '0;
      end
      sq <= '0;
      nz <= '0;
    end else if (tick) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (tone_period[i] == '0) begin
          tcnt[i] <= '0;
          sq[i]   <= 1'b0;
        end else if (tcnt[i] == '0) begin
          tcnt[i] <= tone_reload[i];
          sq[i]   <= ~sq[i];
        end else begin
          tcnt[i] <= tcnt[i] - FREQ_W'(1);
        end
        if (ncnt[i] == '0) begin
          ncnt[i] <= noise_period[i];
          nz[i]   <= lfsr[0];
        end else begin
          ncnt[i] <= ncnt[i] - FREQ_W'(1);
        end
      end
    end
  end

  env_state_t        state    [NUM_CH];
  env_state_t        state_nx [NUM_CH];
  logic [3:0]        level    [NUM_CH];
  logic [3:0]        level_nx [NUM_CH];
  logic [STEP_W-1:0] scnt     [NUM_CH];
  logic [STEP_W-1:0] scnt_nx  [NUM_CH];

  always_comb begin
    logic [STEP_W-1:0] thr;
    logic              step;
    thr  = '0;
    step = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_nx[i] = state[i];
      level_nx[i] = level[i];
      scnt_nx[i]  = scnt[i];
      thr  = (STEP_W'((state[i] == RELEASE) ? release_rate[i] : attack_rate[i]) + STEP_W'(1))
             * STEP_W'(ENV_DIV);
      step = tick && (scnt[i] == thr - STEP_W'(1));
      if (tick) scnt_nx[i] = step ? '0 : scnt[i] + STEP_W'(1);
      case (state[i])
        IDLE: begin
          level_nx[i] = '0;
          if (key_on[i]) state_nx[i] = ATTACK;
        end
        ATTACK: begin
          if (!key_on[i]) state_nx[i] = RELEASE;
          else if (level[i] == 4'd15) begin
            state_nx[i] = SUSTAIN;
            level_nx[i] = sustain[i];
          end else if (step) level_nx[i] = level[i] + 4'd1;
        end
        SUSTAIN: begin
          level_nx[i] = sustain[i];
          if (!key_on[i]) state_nx[i] = RELEASE;
        end
        default: begin
          if (key_on[i]) state_nx[i] = ATTACK;
          else if (level[i] == 4'd0) state_nx[i] = IDLE;
          else if (step) level_nx[i] = level[i] - 4'd1;
        end
      endcase
      if (state_nx[i] != state[i]) scnt_nx[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        level[i] <= '0;
        scnt[i]  <= '0;
      end
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state[i] <= state_nx[i];
        level[i] <= level_nx[i];
        scnt[i]  <= scnt_nx[i];
        busy[i]  <= (state_nx[i] != IDLE);
      end
    end
  end

  logic [NUM_CH-1:0] src;
  logic [MIX_W-1:0]  mix_nx;
  logic [MIX_W-1:0]  mix_sum;
  logic [MIX_W:0]    acc;

  always_comb begin
    src    = '0;
    mix_nx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      case (mix[i])
        2'd0:    src[i] = sq[i];
        2'd1:    src[i] = nz[i];
        2'd2:    src[i] = sq[i] & nz[i];
        default: src[i] = sq[i] ^ nz[i];
      endcase
      if (src[i]) mix_nx = mix_nx + MIX_W'(level[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mix_sum <= '0;
      acc     <= '0;
      spkr    <= 1'b0;
    end else begin
      mix_sum <= mix_nx;
      acc     <= {1'b0, acc[MIX_W-1:0]} + {1'b0, mix_sum};
      spkr    <= acc[MIX_W];
    end
  end

endmodule

// File: tb/tb_poly_sound_generator.sv
// Directed self-checking bench for poly_sound_generator (tick and envelope step every clk).
module tb_poly_sound_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [0:0] cfg_ch;
  logic [1:0] cfg_addr;
  logic [15:0] cfg_data;
  logic [1:0] key_on;
  logic [1:0] busy;
  logic       spkr;

  logic       cfg_we2;
  logic [1:0] cfg_ch2;
  logic [1:0] cfg_addr2;
  logic [15:0] cfg_data2;
  logic [2:0] key_on2;
  logic [2:0] busy2;
  logic       spkr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  poly_sound_generator #(.NUM_CH(2), .FREQ_W(12), .PRESCALE(1), .ENV_DIV(1)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .key_on(key_on), .busy(busy), .spkr(spkr)
  );

  poly_sound_generator #(.NUM_CH(3), .FREQ_W(12), .PRESCALE(1), .ENV_DIV(1)) dut2 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we2), .cfg_ch(cfg_ch2), .cfg_addr(cfg_addr2),
    .cfg_data(cfg_data2), .key_on(key_on2), .busy(busy2), .spkr(spkr2)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; cfg_we = 1'b0; key_on = '0; cfg_we2 = 1'b0; key_on2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cfg_write(input logic ch, input logic [1:0] addr, input logic [15:0] data);
    cfg_we = 1'b1; cfg_ch = ch; cfg_addr = addr; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_write2(input logic [1:0] ch, input logic [1:0] addr, input logic [15:0] data);
    cfg_we2 = 1'b1; cfg_ch2 = ch; cfg_addr2 = addr; cfg_data2 = data;
    @(negedge clk);
    cfg_we2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0; key_on = '0;
    cfg_we2 = 1'b0; cfg_ch2 = '0; cfg_addr2 = '0; cfg_data2 = '0; key_on2 = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", busy); end
    checks++; if (spkr !== 1'b0) begin errors++; $display("FAIL reset_spkr: got %b want 0", spkr); end
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL release_lfsr: got %h want ace1", dut.lfsr); end
    @(negedge clk);
    checks++; if (dut.lfsr !== 16'h59C3) begin errors++; $display("FAIL lfsr_step1: got %h want 59c3", dut.lfsr); end
    checks++; if (dut.nz[0] !== 1'b1) begin errors++; $display("FAIL noise_sample: got %b want 1", dut.nz[0]); end
    @(negedge clk);
    checks++; if (dut.lfsr !== 16'hB387) begin errors++; $display("FAIL lfsr_step2: got %h want b387", dut.lfsr); end
  endtask

  task automatic test_attack_tone();
    int n;
    logic prev;
    do_reset();
    cfg_write(1'b0, 2'd2, 16'h000F);
    cfg_write(1'b0, 2'd0, 16'd10);
    key_on = 2'b01;
    @(negedge clk);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL attack_busy: got %b want 1", busy[0]); end
    n = 0;
    while (dut.level[0] !== 4'd15 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n != 15) begin errors++; $display("FAIL attack_time: got %0d clks want 15", n); end
    repeat (3) @(negedge clk);
    checks++; if (dut.level[0] !== 4'd15) begin errors++; $display("FAIL sustain_level: got %0d want 15", dut.level[0]); end
    prev = dut.sq[0]; n = 0;
    while (dut.sq[0] === prev && n < 30) begin @(negedge clk); n++; end
    prev = dut.sq[0]; n = 0;
    while (dut.sq[0] === prev && n < 30) begin @(negedge clk); n++; end
    checks++; if (n != 11) begin errors++; $display("FAIL tone_half_period: got %0d want 11", n); end
  endtask

  task automatic test_release();
    int n;
    int ones;
    key_on = 2'b00;
    n = 0;
    while (dut.level[0] !== 4'd0 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n != 16) begin errors++; $display("FAIL release_time: got %0d clks want 16", n); end
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL busy_at_zero: got %b want 1", busy[0]); end
    @(negedge clk);
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", busy[0]); end
    repeat (4) @(negedge clk);
    ones = 0;
    repeat (32) begin @(negedge clk); ones += int'(spkr); end
    checks++; if (ones != 0) begin errors++; $display("FAIL idle_spkr: got %0d ones want 0", ones); end
  endtask

  task automatic test_reattack();
    int n;
    do_reset();
    cfg_write(1'b0, 2'd2, 16'h000F);
    key_on = 2'b01;
    n = 0;
    while (dut.level[0] !== 4'd15 && n < 40) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    key_on = 2'b00;
    n = 0;
    while (dut.level[0] !== 4'd6 && n < 40) begin @(negedge clk); n++; end
    key_on = 2'b01;
    @(negedge clk);
    checks++; if (dut.level[0] !== 4'd6) begin errors++; $display("FAIL reattack_level: got %0d want 6", dut.level[0]); end
    n = 0;
    while (dut.level[0] !== 4'd15 && n < 30) begin @(negedge clk); n++; end
    checks++; if (n != 9) begin errors++; $display("FAIL reattack_steps: got %0d want 9", n); end
  endtask

  task automatic test_duty();
    int ones;
    do_reset();
    cfg_write(1'b0, 2'd0, 16'h0FFF);
    cfg_write(1'b0, 2'd2, 16'h0004);
    cfg_write(1'b1, 2'd0, 16'h0FFF);
    cfg_write(1'b1, 2'd2, 16'h0004);
    key_on = 2'b11;
    repeat (40) @(negedge clk);
    for (int w = 0; w < 8; w++) begin
      ones = 0;
      repeat (4) begin @(negedge clk); ones += int'(spkr); end
      checks++;
      if (ones != 1) begin errors++; $display("FAIL duty_window%0d: got %0d ones want 1", w, ones); end
    end
  endtask

  task automatic test_silent_and_bad_ch();
    int ones;
    do_reset();
    cfg_write(1'b0, 2'd2, 16'h000F);
    key_on = 2'b01;
    repeat (30) @(negedge clk);
    ones = 0;
    repeat (64) begin @(negedge clk); ones += int'(spkr); end
    checks++; if (ones != 0) begin errors++; $display("FAIL period0_spkr: got %0d ones want 0", ones); end
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL period0_busy: got %b want 1", busy[0]); end
    cfg_write2(2'd3, 2'd0, 16'h0123);
    checks++;
    if (dut2.tone_period[0] !== 12'h000 || dut2.tone_period[1] !== 12'h000 || dut2.tone_period[2] !== 12'h000) begin
      errors++;
      $display("FAIL bad_ch_write: got %h %h %h want 000 000 000",
               dut2.tone_period[0], dut2.tone_period[1], dut2.tone_period[2]);
    end
    cfg_write2(2'd2, 2'd0, 16'h0055);
    checks++; if (dut2.tone_period[2] !== 12'h055) begin errors++; $display("FAIL ch2_write: got %h want 055", dut2.tone_period[2]); end
  endtask

  task automatic test_reset_mid_sustain();
    do_reset();
    cfg_write(1'b0, 2'd0, 16'd3);
    cfg_write(1'b0, 2'd2, 16'h000F);
    key_on = 2'b01;
    repeat (30) @(negedge clk);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b want 1", busy[0]); end
    #2 reset = 1'b0;
    #1;
    checks++; if (spkr !== 1'b0) begin errors++; $display("FAIL mid_reset_spkr: got %b want 0", spkr); end
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL mid_reset_busy: got %b want 00", busy); end
    checks++; if (dut.level[0] !== 4'd0) begin errors++; $display("FAIL mid_reset_level: got %0d want 0", dut.level[0]); end
    @(negedge clk);
    reset = 1'b1;
    key_on = 2'b00;
    #1;
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL post_reset_lfsr: got %h want ace1", dut.lfsr); end
  endtask

  initial begin
    test_reset();
    test_attack_tone();
    test_release();
    test_reattack();
    test_duty();
    test_silent_and_bad_ch();
    test_reset_mid_sustain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
